// File: rtl/ddr_rd_arb_pkg.sv
// ddr_rd_arb_pkg: shared constants, the AR FSM state type and the AXI size
// helper used by the DDR read arbiter.
//   AXI_BURST_INCR / AXI_CACHE_DEF / AXI_RESP_OKAY : AXI4 encodings
//   ar_state_t                                      : AR FSM states
//   axsize(data_width)                              : log2 of bytes per beat
package ddr_rd_arb_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } ar_state_t;

  // Bytes per beat as an AXI size code; 64-bit data gives 3.
  function automatic logic [2:0] axsize(input int data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((data_width / 8) == (1 << i)) size = i[2:0];
    end
    return size;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered last-grant pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request vector
//   gnt[1:0] : one-hot (or zero) grant, combinational from req
// After reset port 0 has priority; after any grant the other port does.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  import ddr_rd_arb_pkg::*;

  // 1 = port 1 won most recently, so port 0 is preferred on a tie.
  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_gnt)) gnt = 2'b01;
    else if (req[1])                     gnt = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/ddr_rd_arb.sv
// ddr_rd_arb: two-requester burst-read arbiter onto one AXI4 AR/R port.
//   aclk, areset            : clock, asynchronous active-high reset
//   rqN_valid/ready/addr/len: read command from requester N (ready = grant)
//   dtN_valid/ready/data/last/err : read beats routed back by RID
//   m_axi_ar* / m_axi_r*    : AXI4 master read address / data channels
//   bad_id                  : sticky, a beat arrived with an unexpected RID
//   dbg_state               : current AR FSM state
// Optional build macro DDR_RD_ARB_STATS_EN adds 32-bit wrapping counters
// stat_bursts0/1, stat_beats0/1 and stat_err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never waits for ready, and payload is held while valid=1.
module ddr_rd_arb
  import ddr_rd_arb_pkg::*;
#(
  parameter int                  ID_WIDTH       = 6,
  parameter int                  DATA_WIDTH     = 64,
  parameter int                  B_BURST_LENGTH = 4,
  parameter logic [ID_WIDTH-1:0] ID0            = '0,
  parameter logic [ID_WIDTH-1:0] ID1            = ID_WIDTH'(1)
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      rq0_valid,
  output logic                      rq0_ready,
  input  logic [31:0]               rq0_addr,
  input  logic [B_BURST_LENGTH-1:0] rq0_len,
  input  logic                      rq1_valid,
  output logic                      rq1_ready,
  input  logic [31:0]               rq1_addr,
  input  logic [B_BURST_LENGTH-1:0] rq1_len,
  output logic                      dt0_valid,
  input  logic                      dt0_ready,
  output logic [DATA_WIDTH-1:0]     dt0_data,
  output logic                      dt0_last,
  output logic                      dt0_err,
  output logic                      dt1_valid,
  input  logic                      dt1_ready,
  output logic [DATA_WIDTH-1:0]     dt1_data,
  output logic                      dt1_last,
  output logic                      dt1_err,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [31:0]               m_axi_araddr,
  output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      bad_id,
`ifdef DDR_RD_ARB_STATS_EN
  output logic [31:0]               stat_bursts0,
  output logic [31:0]               stat_bursts1,
  output logic [31:0]               stat_beats0,
  output logic [31:0]               stat_beats1,
  output logic [31:0]               stat_err,
`endif
  output ar_state_t                 dbg_state
);

  ar_state_t                 state, state_nxt;
  logic [1:0]                outstanding, arb_req, gnt;
  logic                      ar_port;
  logic [ID_WIDTH-1:0]       ar_id;
  logic [31:0]               ar_addr;
  logic [B_BURST_LENGTH-1:0] ar_len;
  logic                      ar_hs, hit0, hit1;

  // Address bits below the beat size are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rq0_addr[2:0], rq1_addr[2:0]};

  // Eligibility uses the registered outstanding bits, so a burst finishing
  // this cycle only frees its requester for the next cycle.
  assign arb_req = (state == IDLE && !areset) ?
                   {rq1_valid & ~outstanding[1], rq0_valid & ~outstanding[0]} : 2'b00;

  rr_arb2 u_rr (
    .clk (aclk),
    .rst (areset),
    .req (arb_req),
    .gnt (gnt)
  );

  assign rq0_ready = gnt[0];
  assign rq1_ready = gnt[1];
  assign ar_hs     = (state == ADDR) && m_axi_arready;
  assign dbg_state = state;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    case (state)
      IDLE: if (|gnt) state_nxt = ADDR;
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AR payload is captured on the grant and held through the ADDR state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ar_port <= 1'b0;
      ar_id   <= '0;
      ar_addr <= '0;
      ar_len  <= '0;
    end else if (|gnt) begin
      ar_port <= gnt[1];
      ar_id   <= gnt[1] ? ID1 : ID0;
      ar_addr <= gnt[1] ? {rq1_addr[31:3], 3'b000} : {rq0_addr[31:3], 3'b000};
      ar_len  <= gnt[1] ? rq1_len : rq0_len;
    end
  end

  assign m_axi_arid    = ar_id;
  assign m_axi_araddr  = ar_addr;
  assign m_axi_arlen   = ar_len;
  assign m_axi_arsize  = axsize(DATA_WIDTH);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  // A beat belongs to a requester only while that requester has a burst in
  // flight; anything else (including leftovers from before a reset) is
  // swallowed so the slave can never stall on it.
  assign hit0 = (m_axi_rid == ID0) && outstanding[0];
  assign hit1 = (m_axi_rid == ID1) && outstanding[1];

  always_comb begin
    m_axi_rready = 1'b1;
    if (hit0)      m_axi_rready = dt0_ready;
    else if (hit1) m_axi_rready = dt1_ready;
  end

  assign dt0_valid = m_axi_rvalid & hit0;
  assign dt0_data  = m_axi_rdata;
  assign dt0_last  = m_axi_rlast & hit0;
  assign dt0_err   = hit0 & (m_axi_rresp != AXI_RESP_OKAY);
  assign dt1_valid = m_axi_rvalid & hit1;
  assign dt1_data  = m_axi_rdata;
  assign dt1_last  = m_axi_rlast & hit1;
  assign dt1_err   = hit1 & (m_axi_rresp != AXI_RESP_OKAY);

  // Set and clear never target the same bit in one cycle: a bit is set only
  // while clear and cleared only while set.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      outstanding <= 2'b00;
    end else begin
      if (ar_hs) outstanding[ar_port] <= 1'b1;
      if (dt0_valid && dt0_ready && dt0_last) outstanding[0] <= 1'b0;
      if (dt1_valid && dt1_ready && dt1_last) outstanding[1] <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                            bad_id <= 1'b0;
    else if (m_axi_rvalid && !hit0 && !hit1) bad_id <= 1'b1;
  end

`ifdef DDR_RD_ARB_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_bursts0 <= '0;
      stat_bursts1 <= '0;
      stat_beats0  <= '0;
      stat_beats1  <= '0;
      stat_err     <= '0;
    end else begin
      if (ar_hs && !ar_port) stat_bursts0 <= stat_bursts0 + 32'd1;
      if (ar_hs &&  ar_port) stat_bursts1 <= stat_bursts1 + 32'd1;
      if (dt0_valid && dt0_ready) stat_beats0 <= stat_beats0 + 32'd1;
      if (dt1_valid && dt1_ready) stat_beats1 <= stat_beats1 + 32'd1;
      if ((dt0_valid && dt0_ready && dt0_err) || (dt1_valid && dt1_ready && dt1_err))
        stat_err <= stat_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rd_arb.sv
module tb_ddr_rd_arb;
  import ddr_rd_arb_pkg::*;

  localparam int         IDW = 6;
  localparam int         DW  = 64;
  localparam int         LW  = 4;
  localparam logic [5:0] ID0 = 6'd0;
  localparam logic [5:0] ID1 = 6'd1;

  // ---------------- clock / reset ----------------
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic           rq0_valid = 0, rq1_valid = 0;
  logic           rq0_ready, rq1_ready;
  logic [31:0]    rq0_addr = '0, rq1_addr = '0;
  logic [LW-1:0]  rq0_len = '0, rq1_len = '0;
  logic           dt0_valid, dt1_valid, dt0_last, dt1_last, dt0_err, dt1_err;
  logic           dt0_ready = 1, dt1_ready = 1;
  logic [DW-1:0]  dt0_data, dt1_data;
  logic [IDW-1:0] m_axi_arid;
  logic [31:0]    m_axi_araddr;
  logic [LW-1:0]  m_axi_arlen;
  logic [2:0]     m_axi_arsize, m_axi_arprot;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arlock, m_axi_arvalid;
  logic [3:0]     m_axi_arcache, m_axi_arqos;
  logic           m_axi_arready = 0;
  logic [IDW-1:0] m_axi_rid = '0;
  logic [DW-1:0]  m_axi_rdata = '0;
  logic [1:0]     m_axi_rresp = '0;
  logic           m_axi_rlast = 0, m_axi_rvalid = 0;
  logic           m_axi_rready, bad_id;
  ar_state_t      dbg_state;
`ifdef DDR_RD_ARB_STATS_EN
  logic [31:0]    stat_bursts0, stat_bursts1, stat_beats0, stat_beats1, stat_err;
`endif

  ddr_rd_arb #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .B_BURST_LENGTH(LW), .ID0(ID0), .ID1(ID1)
  ) dut (
    .aclk(aclk), .areset(areset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr), .rq0_len(rq0_len),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr), .rq1_len(rq1_len),
    .dt0_valid(dt0_valid), .dt0_ready(dt0_ready), .dt0_data(dt0_data),
    .dt0_last(dt0_last), .dt0_err(dt0_err),
    .dt1_valid(dt1_valid), .dt1_ready(dt1_ready), .dt1_data(dt1_data),
    .dt1_last(dt1_last), .dt1_err(dt1_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .bad_id(bad_id),
`ifdef DDR_RD_ARB_STATS_EN
    .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1),
    .stat_beats0(stat_beats0), .stat_beats1(stat_beats1), .stat_err(stat_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // All stimulus changes and checks happen on the falling edge.
  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({tag, "_rq0_ready"}, 64'(rq0_ready), 64'd0);
    check({tag, "_rq1_ready"}, 64'(rq1_ready), 64'd0);
    check({tag, "_dt0_valid"}, 64'(dt0_valid), 64'd0);
    check({tag, "_dt1_valid"}, 64'(dt1_valid), 64'd0);
    check({tag, "_bad_id"}, 64'(bad_id), 64'd0);
    check({tag, "_arid"}, 64'(m_axi_arid), 64'd0);
    check({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
    check({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    check({tag, "_arsize"}, 64'(m_axi_arsize), 64'd3);
    check({tag, "_arburst"}, 64'(m_axi_arburst), 64'd1);
    check({tag, "_arcache"}, 64'(m_axi_arcache), 64'd3);
    check({tag, "_arlock_prot_qos"}, 64'({m_axi_arlock, m_axi_arprot, m_axi_arqos}), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // Raise a request, wait for its grant, and confirm ready lasts one cycle.
  task automatic issue(input int port, input logic [31:0] addr, input logic [LW-1:0] len);
    int cyc = 0;
    if (port == 0) begin rq0_valid = 1; rq0_addr = addr; rq0_len = len; end
    else           begin rq1_valid = 1; rq1_addr = addr; rq1_len = len; end
    #1;
    while (((port == 0) ? rq0_ready : rq1_ready) !== 1'b1 && cyc < 50) begin
      step(); #1; cyc++;
    end
    check("grant_seen", 64'(cyc < 50), 64'd1);
    step(); #1;
    check("ready_one_cycle", 64'((port == 0) ? rq0_ready : rq1_ready), 64'd0);
    check("arvalid_1_after_grant", 64'(m_axi_arvalid), 64'd1);
    if (port == 0) rq0_valid = 0;
    else           rq1_valid = 0;
  endtask

  // Slave side of AR: optional wait states, field checks, then the handshake.
  task automatic ar_accept(input logic [5:0] id, input logic [31:0] addr,
                           input logic [LW-1:0] len, input int waits);
    int cyc = 0;
    #1;
    while (m_axi_arvalid !== 1'b1 && cyc < 50) begin step(); #1; cyc++; end
    check("arvalid_seen", 64'(m_axi_arvalid), 64'd1);
    for (int i = 0; i < waits; i++) begin
      step(); #1;
      check("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
      check("ar_hold_addr", 64'(m_axi_araddr), 64'(addr));
    end
    check("arid", 64'(m_axi_arid), 64'(id));
    check("araddr", 64'(m_axi_araddr), 64'(addr));
    check("arlen", 64'(m_axi_arlen), 64'(len));
    check("arsize", 64'(m_axi_arsize), 64'd3);
    m_axi_arready = 1;
    step();
    m_axi_arready = 0;
    #1;
    check("arvalid_drop", 64'(m_axi_arvalid), 64'd0);
  endtask

  // Present one R beat and check where it lands. port = -1 means dropped.
  task automatic r_beat(input logic [5:0] id, input logic [63:0] data,
                        input logic last, input logic [1:0] resp, input int port);
    int cyc = 0;
    m_axi_rvalid = 1; m_axi_rid = id; m_axi_rdata = data;
    m_axi_rlast = last; m_axi_rresp = resp;
    #1;
    while (m_axi_rready !== 1'b1 && cyc < 50) begin step(); #1; cyc++; end
    check("rready", 64'(m_axi_rready), 64'd1);
    if (port == 0) begin
      check("dt0_valid", 64'(dt0_valid), 64'd1);
      check("dt1_quiet", 64'(dt1_valid), 64'd0);
      check("exp0_avail", 64'(exp0_q.size() > 0), 64'd1);
      if (exp0_q.size() > 0) check("dt0_data", dt0_data, exp0_q.pop_front());
      check("dt0_last", 64'(dt0_last), 64'(last));
      check("dt0_err", 64'(dt0_err), 64'(resp != 2'b00));
    end else if (port == 1) begin
      check("dt1_valid", 64'(dt1_valid), 64'd1);
      check("dt0_quiet", 64'(dt0_valid), 64'd0);
      check("exp1_avail", 64'(exp1_q.size() > 0), 64'd1);
      if (exp1_q.size() > 0) check("dt1_data", dt1_data, exp1_q.pop_front());
      check("dt1_last", 64'(dt1_last), 64'(last));
      check("dt1_err", 64'(dt1_err), 64'(resp != 2'b00));
    end else begin
      check("drop_dt0_quiet", 64'(dt0_valid), 64'd0);
      check("drop_dt1_quiet", 64'(dt1_valid), 64'd0);
    end
    step();
    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
  endtask

  function automatic logic [63:0] beat_data(input logic [55:0] base, input int i);
    return {base, 8'(i)};
  endfunction

  task automatic send_burst(input logic [5:0] id, input int port, input logic [55:0] base,
                            input int nbeats, input int err_beat);
    for (int i = 0; i < nbeats; i++) begin
      if (port == 0) exp0_q.push_back(beat_data(base, i));
      if (port == 1) exp1_q.push_back(beat_data(base, i));
      r_beat(id, beat_data(base, i), 1'(i == nbeats - 1),
             (i == err_beat) ? 2'b10 : 2'b00, port);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge aclk);
    @(negedge aclk);
    #1;
    check_reset_outputs("por");
    areset = 0;
    step();

    // Contention, first round: fresh pointer favours port 0.
    rq0_valid = 1; rq0_addr = 32'h0000_1000; rq0_len = 4'd3;
    rq1_valid = 1; rq1_addr = 32'h0000_2000; rq1_len = 4'd3;
    #1;
    check("c1_grant0_rq0", 64'(rq0_ready), 64'd1);
    check("c1_grant0_rq1", 64'(rq1_ready), 64'd0);
    step();
    rq0_valid = 0;
    #1;
    check("c1_addr_state", 64'(dbg_state), 64'(ADDR));
    check("c1_rq1_wait", 64'(rq1_ready), 64'd0);
    ar_accept(ID0, 32'h0000_1000, 4'd3, 2);
    check("c1_grant1_rq1", 64'(rq1_ready), 64'd1);
    step();
    rq1_valid = 0;
    ar_accept(ID1, 32'h0000_2000, 4'd3, 0);

    // Contention, second round: both re-request while outstanding; ID1
    // completes first, so the grants come out 1 then 0.
    rq0_valid = 1; rq0_addr = 32'h0000_3000; rq0_len = 4'd1;
    rq1_valid = 1; rq1_addr = 32'h0000_4000; rq1_len = 4'd1;
    #1;
    check("c2_blocked_rq0", 64'(rq0_ready), 64'd0);
    check("c2_blocked_rq1", 64'(rq1_ready), 64'd0);
    send_burst(ID1, 1, 56'h21, 4, -1);
    #1;
    check("c2_grant1_rq1", 64'(rq1_ready), 64'd1);
    check("c2_grant1_rq0", 64'(rq0_ready), 64'd0);
    step();
    rq1_valid = 0;
    ar_accept(ID1, 32'h0000_4000, 4'd1, 0);
    send_burst(ID0, 0, 56'h20, 4, -1);
    #1;
    check("c2_grant2_rq0", 64'(rq0_ready), 64'd1);
    step();
    rq0_valid = 0;
    ar_accept(ID0, 32'h0000_3000, 4'd1, 0);

    // Out-of-order, interleaved return: ID1 leads.
    for (int i = 0; i < 2; i++) begin
      exp1_q.push_back(beat_data(56'h31, i));
      r_beat(ID1, beat_data(56'h31, i), 1'(i == 1), 2'b00, 1);
      exp0_q.push_back(beat_data(56'h30, i));
      r_beat(ID0, beat_data(56'h30, i), 1'(i == 1), 2'b00, 0);
    end

    // Single command, zero wait states.
    issue(0, 32'h1950_0003, 4'd15);
    ar_accept(ID0, 32'h1950_0000, 4'd15, 0);
    send_burst(ID0, 0, 56'h40, 16, -1);

    // Unknown RID and RID of an idle requester are both dropped.
    #1;
    check("bad_id_clear", 64'(bad_id), 64'd0);
    r_beat(6'd5, 64'hdead_beef, 1'b1, 2'b00, -1);
    #1;
    check("bad_id_set", 64'(bad_id), 64'd1);
    r_beat(ID0, 64'h1234, 1'b1, 2'b00, -1);
    step(); step(); #1;
    check("bad_id_sticky", 64'(bad_id), 64'd1);

    // SLVERR on the middle beat only.
    issue(0, 32'h0000_5000, 4'd2);
    ar_accept(ID0, 32'h0000_5000, 4'd2, 1);
    send_burst(ID0, 0, 56'h50, 3, 1);

    // Back-pressure on dt1 with a pending repeat request.
    issue(1, 32'h0000_6000, 4'd7);
    ar_accept(ID1, 32'h0000_6000, 4'd7, 0);
    for (int i = 0; i < 3; i++) begin
      exp1_q.push_back(beat_data(56'h60, i));
      r_beat(ID1, beat_data(56'h60, i), 1'b0, 2'b00, 1);
    end
    rq1_valid = 1; rq1_addr = 32'h0000_7000; rq1_len = 4'd0;
    exp1_q.push_back(beat_data(56'h60, 3));
    m_axi_rvalid = 1; m_axi_rid = ID1; m_axi_rdata = beat_data(56'h60, 3);
    m_axi_rlast = 0; dt1_ready = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("stall_rready", 64'(m_axi_rready), 64'd0);
      check("stall_dt1_valid", 64'(dt1_valid), 64'd1);
      check("stall_rq1_ready", 64'(rq1_ready), 64'd0);
      step();
    end
    dt1_ready = 1;
    r_beat(ID1, beat_data(56'h60, 3), 1'b0, 2'b00, 1);
    for (int i = 4; i < 7; i++) begin
      exp1_q.push_back(beat_data(56'h60, i));
      r_beat(ID1, beat_data(56'h60, i), 1'b0, 2'b00, 1);
    end
    exp1_q.push_back(beat_data(56'h60, 7));
    m_axi_rvalid = 1; m_axi_rid = ID1; m_axi_rdata = beat_data(56'h60, 7); m_axi_rlast = 1;
    #1;
    check("rlast_cycle_no_grant", 64'(rq1_ready), 64'd0);
    r_beat(ID1, beat_data(56'h60, 7), 1'b1, 2'b00, 1);
    #1;
    check("regrant_after_rlast", 64'(rq1_ready), 64'd1);
    step();
    rq1_valid = 0;
    ar_accept(ID1, 32'h0000_7000, 4'd0, 0);
    send_burst(ID1, 1, 56'h61, 1, -1);

    // Reset after beat 5 of 16.
    issue(1, 32'h0000_8000, 4'd15);
    ar_accept(ID1, 32'h0000_8000, 4'd15, 0);
    send_burst(ID1, 1, 56'h70, 5, -1);
    areset = 1;
    #1;
    check_reset_outputs("mid");
    step();
    areset = 0;
    for (int i = 5; i < 16; i++) r_beat(ID1, beat_data(56'h70, i), 1'(i == 15), 2'b00, -1);
    #1;
    check("post_reset_bad_id", 64'(bad_id), 64'd1);
    issue(1, 32'h0000_9000, 4'd3);
    ar_accept(ID1, 32'h0000_9000, 4'd3, 0);
    send_burst(ID1, 1, 56'h81, 4, -1);

    // ---------------- report ----------------
    check("exp0_drained", 64'(exp0_q.size()), 64'd0);
    check("exp1_drained", 64'(exp1_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected sequence end (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
